apb_gcd_host: RTL and testbench
===============================

APB_GCD_HOST -- requirements
Module: apb_gcd_host

Interface
REQ-001 Parameter ADDR_W, default 8, SHALL set the APB address width.
REQ-002 Parameter DATA_W, default 32, SHALL set the APB data width.
REQ-003 Parameter POLL_MAX, default 255, SHALL set the maximum STATUS reads per poll phase before timeout.
REQ-004 Ports SHALL be, in order: clk in 1, clock; rstn in 1, reset, asynchronous and active-low.
REQ-005 Command ports SHALL be: i_a in 8, operand a; i_b in 8, operand b; i_valid in 1, command valid; o_ready out 1, command ready.
REQ-006 Result ports SHALL be: o_gcd out 8, result; o_err out 1, timeout flag; o_valid out 1, result valid; i_ready in 1, result ready.
REQ-007 APB requester ports SHALL be: o_paddr out ADDR_W; o_pwrite out 1; o_psel out 1; o_penable out 1; o_pwdata out DATA_W; i_prdata in DATA_W; i_pready in 1.

Function
REQ-008 The block SHALL act as the APB requester for the GCD peripheral map: CTRL 0x00 (bit0 enable, bit1 intr_en, bit2 intr_type), STATUS 0x04 (bit0 out_valid, bit1 in_ready), DATA_IN 0x08 ({a,b} in bits 15:0), DATA_OUT 0x0C (gcd in bits 7:0).
REQ-009 o_ready SHALL be 1 only in IDLE; a command SHALL be accepted on i_valid && o_ready, with i_a and i_b latched.
REQ-010 Phase FSM states SHALL be IDLE, SETUP, ACCESS, RESP; the op register SHALL take OP_CFG, OP_WAITIN, OP_WR, OP_POLL, OP_RD.
REQ-011 Each transfer SHALL last one SETUP cycle (psel=1, penable=0) followed by ACCESS cycles (psel=1, penable=1) until i_pready=1.
REQ-012 paddr, pwrite and pwdata SHALL stay stable from SETUP through the last ACCESS cycle.
REQ-013 i_prdata SHALL be sampled only in the ACCESS cycle where i_pready=1; there SHALL be no timeout on i_pready.
REQ-014 After a completed transfer, the next transfer's SETUP SHALL follow in the next cycle with no idle cycle.
REQ-015 Op sequence per command SHALL be: OP_CFG (only if init_done=0), OP_WAITIN, OP_WR, OP_POLL, OP_RD, then RESP.
REQ-016 OP_CFG SHALL write 0x00000001 to CTRL and set init_done; interrupts SHALL stay disabled.
REQ-017 OP_WAITIN SHALL read STATUS repeatedly until bit1=1.
REQ-018 OP_WR SHALL write {16'b0, a, b} to DATA_IN.
REQ-019 OP_POLL SHALL read STATUS repeatedly until bit0=1.
REQ-020 OP_RD SHALL read DATA_OUT and capture bits 7:0 into o_gcd.
REQ-021 Poll counter: one counter of width $clog2(POLL_MAX+1) SHALL be cleared when OP_WAITIN or OP_POLL is entered and incremented per completed STATUS read.
REQ-022 Timeout: after POLL_MAX STATUS reads without the awaited bit, the block SHALL go to RESP with o_err=1, o_gcd=0, and clear init_done.
REQ-023 In RESP, o_valid=1 and o_gcd/o_err SHALL hold until i_ready=1; the block SHALL then enter IDLE the next cycle, with no APB activity during RESP.
REQ-024 On a normal completion o_err SHALL be 0.

Reset
REQ-025 On rstn=0, asynchronously: state IDLE, op OP_CFG, init_done=0, counter 0, and o_psel, o_penable, o_pwrite, o_paddr, o_pwdata, o_gcd, o_err, o_valid all 0; o_ready SHALL be 1 after release.
REQ-026 A reset mid-transfer SHALL abandon the transfer immediately, and the next command SHALL begin with OP_CFG.

Structure
REQ-027 A shared package apb_gcd_pkg SHALL hold the register offsets, CTRL/STATUS bit indices, and the phase and op enums.
REQ-028 One sub-module, apb_req_phy, SHALL implement the SETUP/ACCESS handshake (start, write, addr, wdata -> done, rdata); the sequencing FSM SHALL stay in apb_gcd_host.

Verification
REQ-029 Cold start, a=48, b=18 -> transfers: W 0x00=0x1, R 0x04 (in_ready), W 0x08=0x00003012, R 0x04 polls, R 0x0C; then o_valid=1, o_gcd=6, o_err=0.
REQ-030 Second command a=7, b=5 -> no CTRL write; o_gcd=1.
REQ-031 POLL_MAX=4 with a responder whose STATUS bit0 stays 0 -> exactly 4 OP_POLL STATUS reads, then o_err=1, o_gcd=0; next command writes CTRL again.
REQ-032 i_ready held low 10 cycles in RESP -> o_valid, o_gcd stable, o_ready=0, o_psel=0 throughout.
REQ-033 Responder adds 3 wait states per transfer -> paddr/pwdata stable, penable=1 for 4 cycles, result unchanged.
REQ-034 rstn low during OP_POLL ACCESS -> o_psel=o_penable=0 in the same cycle; the next command starts with W 0x00=0x1.

Source files
------------

// File: rtl/apb_gcd_pkg.sv
// Shared definitions for the APB GCD requester: peripheral register map,
// CTRL/STATUS bit positions, and the phase and operation encodings.
package apb_gcd_pkg;

    // Peripheral register offsets
    localparam logic [7:0] REG_CTRL     = 8'h00;
    localparam logic [7:0] REG_STATUS   = 8'h04;
    localparam logic [7:0] REG_DATA_IN  = 8'h08;
    localparam logic [7:0] REG_DATA_OUT = 8'h0C;

    // CTRL bit indices
    localparam int CTRL_ENABLE_BIT    = 0;
    localparam int CTRL_INTR_EN_BIT   = 1;
    localparam int CTRL_INTR_TYPE_BIT = 2;

    // STATUS bit indices
    localparam int STATUS_OUT_VALID_BIT = 0;
    localparam int STATUS_IN_READY_BIT  = 1;

    // Peripheral is only enabled; the host polls, so interrupts stay off.
    localparam logic [31:0] CTRL_INIT = 32'(1) << CTRL_ENABLE_BIT;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ACCESS,
        RESP
    } phase_t;

    typedef enum logic [2:0] {
        OP_CFG,
        OP_WAITIN,
        OP_WR,
        OP_POLL,
        OP_RD
    } op_t;

    // Register targeted by each operation.
    function automatic logic [7:0] op_addr(input op_t op);
        case (op)
            OP_CFG:    return REG_CTRL;
            OP_WAITIN: return REG_STATUS;
            OP_WR:     return REG_DATA_IN;
            OP_POLL:   return REG_STATUS;
            OP_RD:     return REG_DATA_OUT;
            default:   return REG_STATUS;
        endcase
    endfunction

    function automatic logic op_is_write(input op_t op);
        return (op == OP_CFG) || (op == OP_WR);
    endfunction

endpackage

// File: rtl/apb_req_phy.sv
// APB requester phase engine: one SETUP cycle, then ACCESS until pready.
// A start pulse in the completing ACCESS cycle chains straight into the next
// SETUP so back-to-back transfers have no idle cycle between them.
module apb_req_phy #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              start,
    input  logic              write,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic              done,
    output logic [DATA_W-1:0] rdata,
    output logic [ADDR_W-1:0] paddr,
    output logic              pwrite,
    output logic              psel,
    output logic              penable,
    output logic [DATA_W-1:0] pwdata,
    input  logic [DATA_W-1:0] prdata,
    input  logic              pready
);

    // Transfer completes in the ACCESS cycle where the completer is ready.
    assign done  = psel && penable && pready;
    // Only meaningful while done is high; the host samples it only then.
    assign rdata = prdata;

    // Bus-phase registers; address/data/direction latched at SETUP and held.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            psel    <= 1'b0;
            penable <= 1'b0;
            pwrite  <= 1'b0;
            paddr   <= '0;
            pwdata  <= '0;
        end else if (start) begin
            psel    <= 1'b1;
            penable <= 1'b0;
            pwrite  <= write;
            paddr   <= addr;
            pwdata  <= wdata;
        end else if (psel && !penable) begin
            penable <= 1'b1;
        end else if (done) begin
            psel    <= 1'b0;
            penable <= 1'b0;
        end
    end

endmodule

// File: rtl/apb_gcd_host.sv
// Command-driven APB host for the GCD peripheral. Each command configures
// the peripheral once (until a timeout), waits for in_ready, writes the
// operands, polls for out_valid and reads the result back.
//
// state  | meaning
// IDLE   | waiting for a command, o_ready=1
// SETUP  | APB setup cycle of the current op
// ACCESS | APB access cycle(s) of the current op
// RESP   | result/timeout presented, waiting for i_ready
module apb_gcd_host
    import apb_gcd_pkg::*;
#(
    parameter int ADDR_W   = 8,
    parameter int DATA_W   = 32,
    parameter int POLL_MAX = 255
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic [7:0]        i_a,
    input  logic [7:0]        i_b,
    input  logic              i_valid,
    output logic              o_ready,
    output logic [7:0]        o_gcd,
    output logic              o_err,
    output logic              o_valid,
    input  logic              i_ready,
    output logic [ADDR_W-1:0] o_paddr,
    output logic              o_pwrite,
    output logic              o_psel,
    output logic              o_penable,
    output logic [DATA_W-1:0] o_pwdata,
    input  logic [DATA_W-1:0] i_prdata,
    input  logic              i_pready
);

    localparam int CW = $clog2(POLL_MAX + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(POLL_MAX);

    phase_t         state, state_n;
    op_t            op, op_n;
    logic           init_done, init_done_n;
    logic [CW-1:0]  poll_cnt, cnt_n, cnt_inc;
    logic [7:0]     a_q, a_n, b_q, b_n;
    logic [7:0]     gcd_q, gcd_n;
    logic           err_q, err_n;

    logic              xfer_start;
    logic              xfer_write;
    logic [ADDR_W-1:0] xfer_addr;
    logic [DATA_W-1:0] xfer_wdata;
    logic              xfer_done;
    logic [DATA_W-1:0] xfer_rdata;
    logic              unused_rdata;

    assign unused_rdata = ^xfer_rdata[DATA_W-1:8];

    // Sequencer registers.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state     <= IDLE;
            op        <= OP_CFG;
            init_done <= 1'b0;
            poll_cnt  <= '0;
            a_q       <= '0;
            b_q       <= '0;
            gcd_q     <= '0;
            err_q     <= 1'b0;
        end else begin
            state     <= state_n;
            op        <= op_n;
            init_done <= init_done_n;
            poll_cnt  <= cnt_n;
            a_q       <= a_n;
            b_q       <= b_n;
            gcd_q     <= gcd_n;
            err_q     <= err_n;
        end
    end

    // Next phase/op: chains ops on each completed transfer and handles polls.
    always_comb begin
        state_n     = state;
        op_n        = op;
        init_done_n = init_done;
        cnt_n       = poll_cnt;
        cnt_inc     = poll_cnt + 1'b1;
        a_n         = a_q;
        b_n         = b_q;
        gcd_n       = gcd_q;
        err_n       = err_q;
        case (state)
            IDLE: begin
                if (i_valid) begin
                    a_n     = i_a;
                    b_n     = i_b;
                    cnt_n   = '0;
                    op_n    = init_done ? OP_WAITIN : OP_CFG;
                    state_n = SETUP;
                end
            end
            SETUP: state_n = ACCESS;
            ACCESS: begin
                if (xfer_done) begin
                    state_n = SETUP;
                    case (op)
                        OP_CFG: begin
                            init_done_n = 1'b1;
                            cnt_n       = '0;
                            op_n        = OP_WAITIN;
                        end
                        OP_WAITIN, OP_POLL: begin
                            if (xfer_rdata[(op == OP_WAITIN) ? STATUS_IN_READY_BIT
                                                             : STATUS_OUT_VALID_BIT]) begin
                                cnt_n = '0;
                                op_n  = (op == OP_WAITIN) ? OP_WR : OP_RD;
                            end else if (cnt_inc == CNT_MAX) begin
                                // Peripheral never answered: report and force re-init.
                                cnt_n       = cnt_inc;
                                gcd_n       = '0;
                                err_n       = 1'b1;
                                init_done_n = 1'b0;
                                state_n     = RESP;
                            end else begin
                                cnt_n = cnt_inc;
                            end
                        end
                        OP_WR: begin
                            cnt_n = '0;
                            op_n  = OP_POLL;
                        end
                        OP_RD: begin
                            gcd_n   = xfer_rdata[7:0];
                            err_n   = 1'b0;
                            state_n = RESP;
                        end
                        default: state_n = IDLE;
                    endcase
                end
            end
            RESP: begin
                if (i_ready) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    // A transfer is launched whenever the next phase is SETUP, using the next op.
    assign xfer_start = (state_n == SETUP);
    assign xfer_write = op_is_write(op_n);
    assign xfer_addr  = ADDR_W'(op_addr(op_n));
    assign xfer_wdata = (op_n == OP_CFG) ? DATA_W'(CTRL_INIT) :
                        (op_n == OP_WR)  ? DATA_W'({a_q, b_q}) : '0;

    apb_req_phy #(
        .ADDR_W(ADDR_W),
        .DATA_W(DATA_W)
    ) u_phy (
        .clk     (clk),
        .rstn    (rstn),
        .start   (xfer_start),
        .write   (xfer_write),
        .addr    (xfer_addr),
        .wdata   (xfer_wdata),
        .done    (xfer_done),
        .rdata   (xfer_rdata),
        .paddr   (o_paddr),
        .pwrite  (o_pwrite),
        .psel    (o_psel),
        .penable (o_penable),
        .pwdata  (o_pwdata),
        .prdata  (i_prdata),
        .pready  (i_pready)
    );

    assign o_ready = (state == IDLE);
    assign o_valid = (state == RESP);
    assign o_gcd   = gcd_q;
    assign o_err   = err_q;

endmodule

// File: tb/tb_apb_gcd_host.sv
// Bench for apb_gcd_host: behavioural GCD peripheral on the APB side,
// table-driven and randomized commands, plus a mid-poll reset sequence.
module tb_apb_gcd_host;

    localparam int PM = 4;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic [7:0]  i_a = '0, i_b = '0;
    logic        i_valid = 1'b0, i_ready = 1'b0;
    logic        o_ready, o_err, o_valid;
    logic [7:0]  o_gcd;
    logic [7:0]  o_paddr;
    logic        o_pwrite, o_psel, o_penable;
    logic [31:0] o_pwdata;
    logic [31:0] i_prdata = '0;
    logic        i_pready = 1'b0;

    always #5 clk = ~clk;

    apb_gcd_host #(.ADDR_W(8), .DATA_W(32), .POLL_MAX(PM)) dut (
        .clk(clk), .rstn(rstn),
        .i_a(i_a), .i_b(i_b), .i_valid(i_valid), .o_ready(o_ready),
        .o_gcd(o_gcd), .o_err(o_err), .o_valid(o_valid), .i_ready(i_ready),
        .o_paddr(o_paddr), .o_pwrite(o_pwrite), .o_psel(o_psel), .o_penable(o_penable),
        .o_pwdata(o_pwdata), .i_prdata(i_prdata), .i_pready(i_pready)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int ref_gcd(input int a, input int b);
        int x = a;
        int y = b;
        int t;
        while (y != 0) begin
            t = x % y;
            x = y;
            y = t;
        end
        return x;
    endfunction

    typedef struct packed {
        logic        w;
        logic [7:0]  addr;
        logic [31:0] data;
    } xfer_t;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        int         bin;
        int         bp;
        int         ws;
        bit         stuck;
        int         hold;
        logic [7:0] exp_gcd;
        bit         exp_err;
        bit         exp_cfg;
    } vec_t;

    // Peripheral model state
    int          r_bin = 0, r_bp = 0, r_ws = 0;
    bit          r_stuck = 0;
    bit          have_data = 0;
    logic [7:0]  r_result = '0;
    int          acc_n = 0;
    logic [7:0]  s_addr = '0;
    logic [31:0] s_wdata = '0;
    logic        s_write = 1'b0;
    xfer_t       log_q[$];

    // Behavioural GCD peripheral: answers mid-cycle, logs completed transfers.
    always @(negedge clk) begin
        logic [31:0] noise;
        if (!rstn) begin
            i_pready  = 1'b0;
            have_data = 1'b0;
            acc_n     = 0;
        end else if (o_psel && !o_penable) begin
            i_pready = 1'b0;
            acc_n    = 0;
            s_addr   = o_paddr;
            s_wdata  = o_pwdata;
            s_write  = o_pwrite;
        end else if (o_psel && o_penable) begin
            acc_n++;
            chk("paddr_stable", 32'(o_paddr), 32'(s_addr));
            chk("pwdata_stable", o_pwdata, s_wdata);
            chk("pwrite_stable", 32'(o_pwrite), 32'(s_write));
            if (acc_n == r_ws + 1) begin
                i_pready = 1'b1;
                noise = $urandom;
                if (o_pwrite) begin
                    log_q.push_back('{1'b1, o_paddr, o_pwdata});
                    if (o_paddr == 8'h08) begin
                        r_result  = 8'(ref_gcd(int'(o_pwdata[15:8]), int'(o_pwdata[7:0])));
                        have_data = 1'b1;
                    end
                    i_prdata = noise;
                end else begin
                    log_q.push_back('{1'b0, o_paddr, 32'h0});
                    if (o_paddr == 8'h04 && !have_data) begin
                        if (r_bin > 0) begin
                            r_bin--;
                            i_prdata = noise & ~32'h2;
                        end else begin
                            i_prdata = noise | 32'h2;
                        end
                    end else if (o_paddr == 8'h04) begin
                        if (r_stuck || r_bp > 0) begin
                            if (r_bp > 0) r_bp--;
                            i_prdata = noise & ~32'h1;
                        end else begin
                            i_prdata = noise | 32'h1;
                        end
                    end else if (o_paddr == 8'h0C) begin
                        i_prdata  = {noise[31:8], r_result};
                        have_data = 1'b0;
                    end else begin
                        i_prdata = noise;
                    end
                end
            end else begin
                i_pready = 1'b0;
            end
        end else begin
            i_pready = 1'b0;
        end
    end

    task automatic run_cmd(input vec_t v);
        xfer_t exp_q[$];
        int    lat;
        int    exp_lat;
        if (v.exp_cfg) exp_q.push_back('{1'b1, 8'h00, 32'h1});
        for (int i = 0; i <= v.bin; i++) exp_q.push_back('{1'b0, 8'h04, 32'h0});
        exp_q.push_back('{1'b1, 8'h08, {16'h0, v.a, v.b}});
        if (v.stuck) begin
            for (int i = 0; i < PM; i++) exp_q.push_back('{1'b0, 8'h04, 32'h0});
        end else begin
            for (int i = 0; i <= v.bp; i++) exp_q.push_back('{1'b0, 8'h04, 32'h0});
            exp_q.push_back('{1'b0, 8'h0C, 32'h0});
        end
        exp_lat = exp_q.size() * (v.ws + 2);

        @(negedge clk);
        chk("ready_idle", 32'(o_ready), 32'd1);
        log_q.delete();
        have_data = 1'b0;
        r_bin = v.bin; r_bp = v.bp; r_ws = v.ws; r_stuck = v.stuck;
        i_a = v.a; i_b = v.b; i_valid = 1'b1;
        @(posedge clk); #1;
        i_valid = 1'b0;
        i_a = 8'($urandom);
        i_b = 8'($urandom);
        chk("ready_dropped", 32'(o_ready), 32'd0);
        lat = 0;
        while (o_valid !== 1'b1 && lat < 3000) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("resp_valid", 32'(o_valid), 32'd1);
        if (o_valid !== 1'b1) return;
        chk("latency", 32'(lat), 32'(exp_lat));
        chk("gcd", 32'(o_gcd), 32'(v.exp_gcd));
        chk("err", 32'(o_err), 32'(v.exp_err));
        for (int h = 0; h < v.hold; h++) begin
            @(posedge clk); #1;
            chk("hold_valid", 32'(o_valid), 32'd1);
            chk("hold_gcd", 32'(o_gcd), 32'(v.exp_gcd));
            chk("hold_ready", 32'(o_ready), 32'd0);
            chk("hold_psel", 32'(o_psel), 32'd0);
        end
        i_ready = 1'b1;
        @(posedge clk); #1;
        i_ready = 1'b0;
        chk("valid_drop", 32'(o_valid), 32'd0);
        chk("ready_back", 32'(o_ready), 32'd1);
        chk("xfer_count", 32'(log_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < log_q.size(); i++) begin
            chk("xfer_dir", 32'(log_q[i].w), 32'(exp_q[i].w));
            chk("xfer_addr", 32'(log_q[i].addr), 32'(exp_q[i].addr));
            if (exp_q[i].w) chk("xfer_wdata", log_q[i].data, exp_q[i].data);
        end
    endtask

    initial begin
        vec_t tbl[6];
        vec_t v;
        bit   model_init;
        bit   found;

        tbl[0] = '{8'd48,  8'd18, 0, 2, 0, 1'b0, 0,  8'd6,  1'b0, 1'b1};
        tbl[1] = '{8'd7,   8'd5,  0, 0, 0, 1'b0, 0,  8'd1,  1'b0, 1'b0};
        tbl[2] = '{8'd100, 8'd75, 1, 3, 0, 1'b0, 10, 8'd25, 1'b0, 1'b0};
        tbl[3] = '{8'd12,  8'd8,  0, 0, 0, 1'b1, 0,  8'd0,  1'b1, 1'b0};
        tbl[4] = '{8'd81,  8'd27, 2, 1, 3, 1'b0, 0,  8'd27, 1'b0, 1'b1};
        tbl[5] = '{8'd255, 8'd15, 0, 0, 1, 1'b0, 2,  8'd15, 1'b0, 1'b0};

        #2;
        chk("rst_psel", 32'(o_psel), 32'd0);
        chk("rst_penable", 32'(o_penable), 32'd0);
        chk("rst_pwrite", 32'(o_pwrite), 32'd0);
        chk("rst_paddr", 32'(o_paddr), 32'd0);
        chk("rst_pwdata", o_pwdata, 32'd0);
        chk("rst_gcd", 32'(o_gcd), 32'd0);
        chk("rst_err", 32'(o_err), 32'd0);
        chk("rst_valid", 32'(o_valid), 32'd0);
        repeat (3) @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        chk("rst_ready", 32'(o_ready), 32'd1);

        for (int i = 0; i < 6; i++) run_cmd(tbl[i]);
        model_init = 1'b1;

        for (int n = 0; n < 20; n++) begin
            v.a       = 8'($urandom_range(1, 255));
            v.b       = 8'($urandom_range(1, 255));
            v.bin     = $urandom_range(0, 3);
            v.bp      = $urandom_range(0, 3);
            v.ws      = $urandom_range(0, 2);
            v.stuck   = ($urandom_range(0, 7) == 0);
            v.hold    = $urandom_range(0, 3);
            v.exp_err = v.stuck;
            v.exp_gcd = v.stuck ? 8'd0 : 8'(ref_gcd(int'(v.a), int'(v.b)));
            v.exp_cfg = !model_init;
            run_cmd(v);
            model_init = !v.stuck;
        end

        // Reset while an OP_POLL transfer sits in ACCESS.
        @(negedge clk);
        log_q.delete();
        have_data = 1'b0;
        r_bin = 0; r_bp = 0; r_ws = 2; r_stuck = 1'b1;
        i_a = 8'd9; i_b = 8'd6; i_valid = 1'b1;
        @(posedge clk); #1;
        i_valid = 1'b0;
        found = 1'b0;
        for (int c = 0; c < 200 && !found; c++) begin
            @(negedge clk);
            if (o_psel && o_penable && o_paddr == 8'h04 && have_data) found = 1'b1;
        end
        chk("poll_access_seen", 32'(found), 32'd1);
        rstn = 1'b0;
        #1;
        chk("abort_psel", 32'(o_psel), 32'd0);
        chk("abort_penable", 32'(o_penable), 32'd0);
        chk("abort_valid", 32'(o_valid), 32'd0);
        repeat (3) @(negedge clk);
        rstn = 1'b1;
        run_cmd('{8'd9, 8'd6, 0, 1, 0, 1'b0, 0, 8'd3, 1'b0, 1'b1});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
